onchip_mem_pipelined: RTL
=========================

# onchip_mem_pipelined

Parametrised Avalon-MM on-chip RAM slave for the Nios II system, used for program/data memory and scratch buffers. It replaces the fixed 16-bit single-port memory with configurable width and depth, 1- or 2-cycle pipelined reads with `readdatavalid`, `waitrequest` flow control, and a hardware clear engine that zeroes the array on request. It sits directly on the system interconnect as a pipelined slave.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8, 8..128.
- `DEPTH`, 15360: number of words; address width `ADDR_W = $clog2(DEPTH)` is derived, not a parameter.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `INIT_FILE`, "onchip_mem.hex": power-up contents; empty string means uninitialised.

- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `clken` in 1: clock enable; low freezes the pipeline and the clear engine.
- `chipselect` in 1: slave select.
- `read` in 1: read request.
- `write` in 1: write request.
- `address` in ADDR_W: word address.
- `byteenable` in DATA_W/8: per-byte write enable.
- `writedata` in DATA_W: write data.
- `readdata` out DATA_W: read data, qualified by `readdatavalid`.
- `readdatavalid` out 1: one-cycle pulse per accepted read.
- `waitrequest` out 1: high means the request is not accepted this cycle.
- `clear` in 1: one-cycle pulse that starts zeroing the array.
- `busy` out 1: clear engine active.

## Operation
- Accept = `chipselect & (read | write) & ~waitrequest`.
- `waitrequest = busy | ~clken`. The signal is combinational and must not depend on `read` or `write`.
- Write: each byte lane with `byteenable[i]=1` is updated at the accepting edge. Other lanes keep their value.
- `read` and `write` both high: the write is performed and the read is dropped, with no `readdatavalid` for it.
- `address >= DEPTH`: a write is discarded. A read returns all-zero data with the normal `readdatavalid`.
- Reads are fully pipelined, one per cycle. `readdatavalid` is the accepted-read flag delayed by READ_LATENCY.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on `clear=1 & clken`. The counter loads 0.
  - In CLEAR, one word is written with zero per enabled cycle and the counter increments.
  - CLEAR -> IDLE after word DEPTH-1 is written.
  - `busy=1` exactly while in CLEAR.
- A `clear` pulse arriving while already in CLEAR is ignored; it is not queued.
- Reads accepted before CLEAR entry drain normally and return pre-clear data.
- Reset values: `readdata=0`, `readdatavalid=0`, `busy=0`, FSM=IDLE, counter=0, pipeline valid bits 0.
- Reset does not alter the array contents.
- Reset during CLEAR: the FSM returns to IDLE. Words already written stay zero and the rest are unchanged. In-flight reads are discarded, with no `readdatavalid`.

## Timing
- Read accepted at edge N: `readdata`/`readdatavalid` are valid after edge N+READ_LATENCY, for exactly one cycle if `clken` stays high.
- `clken` low: all pipeline registers, valid bits, FSM and counter hold. Outputs keep their values.
- A valid pulse held by `clken` low stays high until the pipeline advances. Masters count a beat only when `clken` is high.
- Write-then-read to the same address on consecutive accepted cycles returns the new data.
- Clear takes exactly DEPTH enabled cycles. `waitrequest` is high from the edge after `clear` is sampled until the edge after the last zero write.
- No combinational path from any input to `readdata` or `readdatavalid`.

## Configuration
- `ONCHIP_MEM_RDW_FWD_EN` defined: a read accepted in the same cycle as a write to the same address returns the newly written bytes, merged per `byteenable`. This is only possible from two masters via the arbiter, so the slave accepts both; without the macro, the write-wins rule applies.
- Without the macro: same-cycle read-during-write behaviour follows the rule in Operation (the read is dropped). The RAM core is built with don't-care read-during-write so it maps to a plain M9K/M10K block.

## Structure
- `onchip_mem_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_CLEAR`);
  - the `byte_lanes(DATA_W)` helper;
  - the legal READ_LATENCY constants.
- One sub-module, `onchip_mem_ram_core`: an inferred single-port byte-enabled RAM with a registered output, INIT_FILE load, and a write port shared between the bus and the clear engine. The top block holds the mux, FSM, counter and valid pipeline.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5 with `byteenable=4'hF`, then read addr 5 -> `readdata=0xDEADBEEF`, `readdatavalid` exactly 2 cycles after acceptance (READ_LATENCY=2).
- Write 0x11223344 with `byteenable=4'b0101` over prior 0xAAAAAAAA -> read returns 0xAA22AA44.
- Back-to-back reads of addrs 0..7 with `clken` low for 3 cycles mid-burst -> 8 valid pulses in order, no loss or duplication.
- Pulse `clear` with DEPTH=16 -> `busy`/`waitrequest` high for exactly 16 enabled cycles; subsequent reads of all words return 0; a second `clear` pulse during CLEAR does not extend it.
- Assert `reset_n` low at clear counter=7 (DEPTH=16) -> FSM idle, `busy=0`; words 0..6 are zero and words 7..15 are unchanged.
- Read addr DEPTH (out of range) -> `readdata=0` with `readdatavalid`; write to addr DEPTH leaves all words unchanged.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_pkg
// Description : Shared constants for the pipelined on-chip RAM slave. These
//               are the clear-engine state codes, the legal read latencies and
//               the byte-lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package onchip_mem_pkg;

    typedef logic [0:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 1'b0;
    localparam clr_state_t ST_CLEAR = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_ram_core.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_ram_core
// Description : Inferred single-port byte-enabled RAM with a registered read
//               port. Out-of-range writes are dropped and out-of-range reads
//               return zero. With ONCHIP_MEM_RDW_FWD_EN defined, a read that
//               coincides with a write returns the newly written bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_ram_core
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 15360,
    parameter string INIT_FILE = "onchip_mem.hex",
    localparam int   ADDR_W    = $clog2(DEPTH),
    localparam int   LANES     = byte_lanes(DATA_W)
) (
    input  logic              clk_i,
    input  logic              clken_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [LANES-1:0]  be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    assign in_range = ({1'b0, addr_i} < DEPTH_C);

    always_ff @(posedge clk_i) begin
        if (clken_i && we_i && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

`ifdef ONCHIP_MEM_RDW_FWD_EN
    // Write-first per lane so a same-cycle read sees the merged word.
    always_comb begin
        rd_word = mem[addr_i];
        for (int i = 0; i < LANES; i++) begin
            if (we_i && be_i[i]) begin
                rd_word[i*8 +: 8] = wdata_i[i*8 +: 8];
            end
        end
    end
`else
    assign rd_word = mem[addr_i];
`endif

    always_ff @(posedge clk_i) begin
        if (clken_i && re_i) begin
            rdata_q <= in_range ? rd_word : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/onchip_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_pipelined
// Description : Avalon-MM pipelined on-chip RAM slave with configurable width,
//               depth and read latency, waitrequest flow control, and a
//               hardware clear engine that zeroes the array on request.
//               Optional macro: ONCHIP_MEM_RDW_FWD_EN, which accepts
//               same-cycle read+write and forwards the written bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 15360,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = "onchip_mem.hex",
    localparam int   ADDR_W       = $clog2(DEPTH),
    localparam int   LANES        = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [LANES-1:0]  byteenable,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    input  logic              clear,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    clr_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [READ_LATENCY:0] vld_q;
    logic [DATA_W-1:0]   readdata_q;
    logic [DATA_W-1:0]   stage_data;

    logic                clearing;
    logic                bus_ok;
    logic                wr_acc;
    logic                rd_acc;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [LANES-1:0]    ram_be;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    assign clearing    = (state_q == ST_CLEAR);
    assign busy        = clearing;
    assign waitrequest = clearing | ~clken;

    assign bus_ok = chipselect & ~waitrequest;
    assign wr_acc = bus_ok & write;
`ifdef ONCHIP_MEM_RDW_FWD_EN
    assign rd_acc = bus_ok & read;
`else
    assign rd_acc = bus_ok & read & ~write;
`endif

    // The clear engine owns the single write port while it runs.
    assign ram_we    = clearing | wr_acc;
    assign ram_addr  = clearing ? cnt_q : address;
    assign ram_be    = clearing ? {LANES{1'b1}} : byteenable;
    assign ram_wdata = clearing ? '0 : writedata;

    onchip_mem_ram_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram_core (
        .clk_i   (clk),
        .clken_i (clken),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .re_i    (rd_acc),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clken) begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= {vld_q[READ_LATENCY-1:0], rd_acc};
        end
    end

    // vld_q[0] marks the RAM output register; each extra latency cycle adds a stage.
    generate
        if (READ_LATENCY >= RD_LAT_MAX) begin : g_lat2
            logic [DATA_W-1:0] mid_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mid_q <= '0;
                end else if (clken && vld_q[0]) begin
                    mid_q <= ram_rdata;
                end
            end
            assign stage_data = mid_q;
        end else begin : g_lat1
            assign stage_data = ram_rdata;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (clken && vld_q[READ_LATENCY-1]) begin
            readdata_q <= stage_data;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = vld_q[READ_LATENCY];

endmodule
`default_nettype wire
